// File: rtl/shift_sequencer.sv
// shift_sequencer: parallel-in/serial-out word sequencer with valid/ready on both sides.
// Emits WIDTH bits MSB- or LSB-first, pulses done after the last bit, supports abort.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_lsb,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_bit,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_cnt
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = in_valid ? SHIFT : IDLE;
            SHIFT:   state_d = abort ? IDLE : (out_ready && cnt_q == LAST) ? DONE : SHIFT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // Abort wins over a simultaneous transfer, so the counter clears instead of advancing.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: if (in_valid) begin
                shreg_d = in_data;
                dir_d   = in_lsb;
                cnt_d   = '0;
            end
            SHIFT: if (abort) begin
                cnt_d = '0;
            end else if (out_ready) begin
                shreg_d = dir_q ? {1'b0, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + CNT_W'(1);
            end
            default: cnt_d = '0;
        endcase
    end
    always_comb begin
        in_ready  = state_q == IDLE;
        out_valid = state_q == SHIFT;
        busy      = state_q != IDLE;
        done      = state_q == DONE;
        out_bit   = out_valid && (dir_q ? shreg_q[0] : shreg_q[WIDTH-1]);
        bit_cnt   = cnt_q;
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed checks of the shift_sequencer handshake, bit order and abort/reset.
module tb_shift_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_lsb;
    logic       in_valid;
    logic       in_ready;
    logic       out_bit;
    logic       out_valid;
    logic       out_ready;
    logic       abort;
    logic       busy;
    logic       done;
    logic [3:0] bit_cnt;
    int checks = 0;
    int errors = 0;

    shift_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_lsb(in_lsb),
        .in_valid(in_valid), .in_ready(in_ready), .out_bit(out_bit),
        .out_valid(out_valid), .out_ready(out_ready), .abort(abort),
        .busy(busy), .done(done), .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled at the falling edge.
    task automatic send(input logic [7:0] word, input logic lsb);
        in_data  = word;
        in_lsb   = lsb;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data   = 8'($urandom);
            in_lsb    = 1'($urandom);
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            abort     = 1'($urandom);
            @(negedge clk);
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || bit_cnt !== 4'd0 || out_bit !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b done=%b busy=%b bit_cnt=%0d out_bit=%b, want 1 0 0 0 0 0",
                     in_ready, out_valid, done, busy, bit_cnt, out_bit);
        end
        reset = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: in_ready=%b busy=%b, want 1 0", in_ready, busy);
        end
    endtask

    // Full-rate stream; exp holds the expected serial order with the first bit at [7].
    task automatic test_stream(input string name, input logic [7:0] word, input logic lsb,
                               input logic [7:0] exp, input logic intrude);
        out_ready = 1'b1;
        send(word, lsb);
        for (int i = 0; i < 8; i++) begin
            if (intrude) begin
                in_valid = 1'b1;
                in_data  = 8'hFF;
            end
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || out_bit !== exp[7-i] || bit_cnt !== 4'(i)) begin
                errors++;
                $display("FAIL %s bit%0d: out_valid=%b in_ready=%b busy=%b out_bit=%b bit_cnt=%0d, want 1 0 1 %b %0d",
                         name, i, out_valid, in_ready, busy, out_bit, bit_cnt, exp[7-i], i);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1 || bit_cnt !== 4'd8) begin
            errors++;
            $display("FAIL %s done: done=%b out_valid=%b in_ready=%b busy=%b bit_cnt=%0d, want 1 0 0 1 8",
                     name, done, out_valid, in_ready, busy, bit_cnt);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || bit_cnt !== 4'd0) begin
            errors++;
            $display("FAIL %s idle: in_ready=%b done=%b busy=%b bit_cnt=%0d, want 1 0 0 0",
                     name, in_ready, done, busy, bit_cnt);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] exp = 8'b11010000;
        int n = 0;
        int cyc = 0;
        out_ready = 1'b1;
        send(8'b11010000, 1'b0);
        while (n < 8 && cyc < 40) begin
            out_ready = (cyc % 2) == 0;
            checks++;
            if (out_valid !== 1'b1 || done !== 1'b0 || out_bit !== exp[7-n] || bit_cnt !== 4'(n)) begin
                errors++;
                $display("FAIL backpressure cyc%0d: out_valid=%b done=%b out_bit=%b bit_cnt=%0d, want 1 0 %b %0d",
                         cyc, out_valid, done, out_bit, bit_cnt, exp[7-n], n);
            end
            if (out_ready) n++;
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (n != 8 || done !== 1'b1) begin
            errors++;
            $display("FAIL backpressure done: transfers=%0d done=%b, want 8 1", n, done);
        end
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abort_reset;
        out_ready = 1'b1;
        send(8'hA5, 1'b0);
        for (int i = 0; i < 10 && bit_cnt != 4'd3; i++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0 || out_valid !== 1'b0 || bit_cnt !== 4'd0) begin
            errors++;
            $display("FAIL abort: busy=%b in_ready=%b done=%b out_valid=%b bit_cnt=%0d, want 0 1 0 0 0",
                     busy, in_ready, done, out_valid, bit_cnt);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_nodone: done=%b busy=%b, want 0 0", done, busy);
        end
        send(8'h3C, 1'b1);
        for (int i = 0; i < 10 && bit_cnt != 4'd5; i++) @(negedge clk);
        checks++;
        if (bit_cnt !== 4'd5 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: bit_cnt=%0d out_valid=%b, want 5 1", bit_cnt, out_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || bit_cnt !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset: out_valid=%b done=%b in_ready=%b busy=%b bit_cnt=%0d, want 0 0 1 0 0",
                     out_valid, done, in_ready, busy, bit_cnt);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_nodone: done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    initial begin
        reset = 1'b1; in_data = '0; in_lsb = 1'b0; in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream("msb_first", 8'b10110001, 1'b0, 8'b10110001, 1'b0);
        test_stream("lsb_first", 8'b10110001, 1'b1, 8'b10001101, 1'b0);
        test_backpressure();
        test_stream("ignore_in", 8'b10110001, 1'b0, 8'b10110001, 1'b1);
        test_abort_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
